// File: rtl/lsu_ma_pkg.sv
// Shared definitions for the load/store unit memory-access stage:
// RV32I width codes, FSM encoding, default RAM address width.
package lsu_ma_pkg;

    localparam int DRWIDTH_DEF = 11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Unsupported width codes count as aligned; they are filtered elsewhere.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return ~off[0];
            F3_W:        return (off == 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data alignment: picks the byte/halfword at the byte offset inside
// the fetched word and sign- or zero-extends it to 32 bits.
module lsu_align
    import lsu_ma_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            F3_W:    result = rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ma.sv
// Memory-access stage: drives a synchronous data RAM for loads/stores,
// returns aligned load data with a one-entry hold buffer for backpressure.
module lsu_ma
    import lsu_ma_pkg::*;
#(
    parameter int DRWIDTH = DRWIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_load,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [4:0]         req_rd,
    output logic [DRWIDTH-1:0] ram_radr,
    output logic [DRWIDTH-1:0] ram_wadr,
    output logic [31:0]        ram_wdata,
    output logic [3:0]         ram_wen,
    input  logic [31:0]        ram_rdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic [4:0]         rsp_rd,
    output logic               misalign_exc,
    output logic [31:0]        misalign_addr
);

    state_e      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic        misalign_exc_q, misalign_exc_d;
    logic [31:0] misalign_addr_q, misalign_addr_d;

    logic        accept, is_load, is_store, aligned;
    logic        load_acc, store_ok, misaligned;
    logic [31:0] align_data;

    // One aligner serves both the live response and the hold capture.
    lsu_align u_align (
        .rdata  (ram_rdata),
        .funct3 (f3_q),
        .offset (off_q),
        .result (align_data)
    );

    always_comb begin
        accept     = req_valid & req_ready;
        is_store   = req_store;
        is_load    = req_load & ~req_store;
        aligned    = is_aligned(req_funct3, req_addr[1:0]);
        load_acc   = accept & is_load & aligned;
        store_ok   = accept & is_store & aligned &
                     ((req_funct3 == F3_B) | (req_funct3 == F3_H) | (req_funct3 == F3_W));
        misaligned = accept & (is_load | is_store) & ~aligned;
    end

    assign ram_radr = req_addr[DRWIDTH+1:2];
    assign ram_wadr = req_addr[DRWIDTH+1:2];

    always_comb begin
        case (req_funct3)
            F3_B:    ram_wdata = {4{req_wdata[7:0]}};
            F3_H:    ram_wdata = {2{req_wdata[15:0]}};
            default: ram_wdata = req_wdata;
        endcase
        ram_wen = 4'b0000;
        if (store_ok) begin
            case (req_funct3)
                F3_B:    ram_wen = 4'b0001 << req_addr[1:0];
                F3_H:    ram_wen = 4'b0011 << req_addr[1:0];
                default: ram_wen = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            f3_q            <= 3'b000;
            off_q           <= 2'b00;
            rd_q            <= 5'd0;
            hold_data_q     <= 32'h0000_0000;
            hold_rd_q       <= 5'd0;
            misalign_exc_q  <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            f3_q            <= f3_d;
            off_q           <= off_d;
            rd_q            <= rd_d;
            hold_data_q     <= hold_data_d;
            hold_rd_q       <= hold_rd_d;
            misalign_exc_q  <= misalign_exc_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_acc) state_d = S_RD;
            S_RD: begin
                if (!rsp_ready)     state_d = S_HOLD;
                else if (!load_acc) state_d = S_IDLE;
            end
            S_HOLD:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        f3_d            = load_acc ? req_funct3 : f3_q;
        off_d           = load_acc ? req_addr[1:0] : off_q;
        rd_d            = load_acc ? req_rd : rd_q;
        hold_data_d     = hold_data_q;
        hold_rd_d       = hold_rd_q;
        if ((state_q == S_RD) && !rsp_ready) begin
            hold_data_d = align_data;
            hold_rd_d   = rd_q;
        end
        misalign_exc_d  = misaligned;
        misalign_addr_d = misaligned ? req_addr : misalign_addr_q;
    end

    // Outputs are gated by rst so nothing stale leaks during the reset cycle.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0000_0000;
        rsp_rd    = 5'd0;
        if (!rst) begin
            case (state_q)
                S_IDLE: req_ready = 1'b1;
                S_RD: begin
                    req_ready = rsp_ready;
                    rsp_valid = 1'b1;
                    rsp_data  = align_data;
                    rsp_rd    = rd_q;
                end
                S_HOLD: begin
                    rsp_valid = 1'b1;
                    rsp_data  = hold_data_q;
                    rsp_rd    = hold_rd_q;
                end
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign misalign_exc  = misalign_exc_q & ~rst;
    assign misalign_addr = rst ? 32'h0000_0000 : misalign_addr_q;

endmodule
